// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the receiver state encoding, parity-mode constants and small arithmetic helpers.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_cycle(input int clk_fre, input int baud);
        return (clk_fre * 1000000) / baud;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sfifo.sv
// Synchronous show-ahead FIFO; head word is visible whenever empty is low.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module uart_rx_sfifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees the slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo_ext.sv
// Parametrised UART receiver with majority-voted sampling, parity/framing/break
// detection and an output FIFO presented on a valid/ready interface.
module uart_rx_fifo_ext
    import uart_rx_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_data_valid,
    input  logic                 rx_data_ready,
    output logic                 rx_break,
    output logic                 rx_overrun
);
    localparam int CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam int HALF  = CYCLE / 2;
    localparam int CW    = $clog2(CYCLE);
    localparam int BW    = $clog2(DATA_BITS + 1);
    localparam int WW    = DATA_BITS + 2;

    rx_state_t            state_reg, state_next;
    logic                 s0_reg, s1_reg;
    logic [CW-1:0]        cnt_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic                 stop_cnt_reg;
    logic [1:0]           samp_reg;
    logic                 bit_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 par_bit_reg;
    logic                 fe_reg;

    logic                 fall, cnt_last, at_mid, maj_now, stop_final;
    logic                 push, shift_en, push_fe, push_pe, brk_cond;
    logic [DATA_BITS-1:0] bit_we;
    logic                 fifo_full, fifo_empty, pop;
    logic [WW-1:0]        head;

    assign fall       = s1_reg & ~s0_reg;
    assign cnt_last   = (cnt_reg == CW'(CYCLE - 1));
    assign at_mid     = (cnt_reg == CW'(HALF));
    // Third vote is the live sample so the final stop bit can finish right at mid-bit.
    assign maj_now    = majority3(samp_reg[0], samp_reg[1], s0_reg);
    assign stop_final = (stop_cnt_reg == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (fall) state_next = ST_START;
            ST_START:  if (cnt_last) state_next = bit_reg ? ST_IDLE : ST_DATA;
            ST_DATA:   if (cnt_last && bit_cnt_reg == BW'(DATA_BITS - 1))
                           state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (cnt_last) state_next = ST_STOP;
            ST_STOP:   if (stop_final && at_mid) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        push     = (state_reg == ST_STOP) && stop_final && at_mid;
        shift_en = (state_reg == ST_DATA) && cnt_last;
    end

    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_bit_we
            assign bit_we[gi] = shift_en && (bit_cnt_reg == BW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_reg       <= 1'b1;
            s1_reg       <= 1'b1;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            samp_reg     <= 2'b11;
            bit_reg      <= 1'b1;
            data_reg     <= '0;
            par_bit_reg  <= 1'b0;
            fe_reg       <= 1'b0;
        end else begin
            s0_reg <= rx_pin;
            s1_reg <= s0_reg;
            cnt_reg <= (state_next != state_reg || cnt_last) ? '0 : cnt_reg + 1'b1;
            if (cnt_reg == CW'(HALF - 2)) samp_reg[0] <= s0_reg;
            if (cnt_reg == CW'(HALF - 1)) samp_reg[1] <= s0_reg;
            if (at_mid) bit_reg <= maj_now;
            if (state_reg == ST_IDLE) bit_cnt_reg <= '0;
            else if (shift_en)        bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (state_reg != ST_STOP) stop_cnt_reg <= 1'b0;
            else if (cnt_last)        stop_cnt_reg <= 1'b1;
            if (state_reg == ST_IDLE) fe_reg <= 1'b0;
            else if (state_reg == ST_STOP && at_mid && !maj_now) fe_reg <= 1'b1;
            if (state_reg == ST_PARITY && cnt_last) par_bit_reg <= bit_reg;
            data_reg <= (data_reg & ~bit_we) | ({DATA_BITS{bit_reg}} & bit_we);
        end
    end

    assign push_fe  = fe_reg | ~maj_now;
    assign push_pe  = (PARITY == PAR_NONE) ? 1'b0 :
                      ((^data_reg ^ par_bit_reg) != (PARITY == PAR_ODD));
    assign brk_cond = (data_reg == '0) && (PARITY == PAR_NONE || !par_bit_reg) && push_fe;

    assign pop = rx_data_valid & rx_data_ready;

    uart_rx_sfifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({push_fe, push_pe, data_reg}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_data_valid = ~fifo_empty;
    assign {rx_frame_err, rx_parity_err, rx_data} = fifo_empty ? '0 : head;
    assign rx_break   = push & brk_cond;
    assign rx_overrun = push & fifo_full & ~pop;

endmodule

// File: tb/tb_uart_rx_fifo_ext.sv
// Bench for uart_rx_fifo_ext: three configurations driven by serial frame tasks,
// checked against a queue model of expected {frame_err, parity_err, data} words.
module tb_uart_rx_fifo_ext;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pin   [3];
    logic       ready [3];
    logic       v [3], pe [3], fe [3], brk [3], ovr [3];
    logic [7:0] d0, d1;
    logic [6:0] d2;

    int cyc_a [3] = '{434, 40, 40};
    int nb_a  [3] = '{8, 8, 7};
    int pm_a  [3] = '{0, 0, 2};
    int ns_a  [3] = '{1, 1, 2};

    logic [10:0] exp_q [3][$];
    int exp_ovr [3] = '{0, 0, 0};
    int exp_brk [3] = '{0, 0, 0};
    int ovr_cnt [3] = '{0, 0, 0};
    int brk_cnt [3] = '{0, 0, 0};
    int checks = 0;
    int failures = 0;

    uart_rx_fifo_ext #(.CLK_FRE(50), .BAUD_RATE(115200)) u_slow (
        .clk(clk), .rst_n(rst_n), .rx_pin(pin[0]), .rx_data(d0), .rx_parity_err(pe[0]),
        .rx_frame_err(fe[0]), .rx_data_valid(v[0]), .rx_data_ready(ready[0]),
        .rx_break(brk[0]), .rx_overrun(ovr[0]));
    uart_rx_fifo_ext #(.CLK_FRE(50), .BAUD_RATE(1250000)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rx_pin(pin[1]), .rx_data(d1), .rx_parity_err(pe[1]),
        .rx_frame_err(fe[1]), .rx_data_valid(v[1]), .rx_data_ready(ready[1]),
        .rx_break(brk[1]), .rx_overrun(ovr[1]));
    uart_rx_fifo_ext #(.CLK_FRE(50), .BAUD_RATE(1250000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
        .clk(clk), .rst_n(rst_n), .rx_pin(pin[2]), .rx_data(d2), .rx_parity_err(pe[2]),
        .rx_frame_err(fe[2]), .rx_data_valid(v[2]), .rx_data_ready(ready[2]),
        .rx_break(brk[2]), .rx_overrun(ovr[2]));

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ovr[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
            if (brk[i] === 1'b1) brk_cnt[i] <= brk_cnt[i] + 1;
        end
    end

    function automatic logic [10:0] head(input int s);
        case (s)
            0:       return {fe[0], pe[0], 1'b0, d0};
            1:       return {fe[1], pe[1], 1'b0, d1};
            default: return {fe[2], pe[2], 2'b0, d2};
        endcase
    endfunction

    // Drives one frame on DUT s and records the word the receiver should deliver.
    task automatic send_frame(input int s, input logic [8:0] data, input bit par_flip,
                              input bit stop_zero, input int glitch_bit, input int last_stop_len);
        int c = cyc_a[s];
        int ones;
        logic [8:0] dm;
        logic pbit;
        bit is_brk;
        dm = data & ((9'd1 << nb_a[s]) - 9'd1);
        ones = $countones(dm);
        pbit = ((pm_a[s] == 1) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ par_flip;
        pin[s] = 1'b0;
        repeat (c) @(negedge clk);
        for (int i = 0; i < nb_a[s]; i++) begin
            pin[s] = dm[i];
            if (i == glitch_bit) begin
                repeat (c / 2) @(negedge clk);
                pin[s] = ~dm[i];
                @(negedge clk);
                pin[s] = dm[i];
                repeat (c - c / 2 - 1) @(negedge clk);
            end else begin
                repeat (c) @(negedge clk);
            end
        end
        if (pm_a[s] != 0) begin
            pin[s] = pbit;
            repeat (c) @(negedge clk);
        end
        for (int k = 0; k < ns_a[s]; k++) begin
            pin[s] = (stop_zero && k == 0) ? 1'b0 : 1'b1;
            repeat ((k == ns_a[s] - 1) ? last_stop_len : c) @(negedge clk);
        end
        pin[s] = 1'b1;
        is_brk = (dm == 9'd0) && (pm_a[s] == 0 || pbit == 1'b0) && stop_zero;
        if (is_brk) exp_brk[s]++;
        if (exp_q[s].size() < 4) exp_q[s].push_back({stop_zero, (pm_a[s] != 0) && par_flip, dm});
        else exp_ovr[s]++;
    endtask

    // Pops every expected word one at a time, then requires the FIFO to be empty.
    task automatic drain_check(input int s, input string name);
        logic [10:0] e;
        while (exp_q[s].size() > 0) begin
            e = exp_q[s].pop_front();
            checks++;
            if (v[s] !== 1'b1 || head(s) !== e) begin
                failures++;
                $display("FAIL %s: valid=%b word=%h required valid=1 word=%h", name, v[s], head(s), e);
            end
            ready[s] = 1'b1;
            @(negedge clk);
            ready[s] = 1'b0;
        end
        checks++;
        if (v[s] !== 1'b0) begin
            failures++;
            $display("FAIL %s_empty: valid=%b required 0", name, v[s]);
        end
    endtask

    task automatic check_counts(input int s, input string name);
        checks++;
        if (ovr_cnt[s] !== exp_ovr[s] || brk_cnt[s] !== exp_brk[s]) begin
            failures++;
            $display("FAIL %s_pulses: overrun=%0d break=%0d required overrun=%0d break=%0d",
                     name, ovr_cnt[s], brk_cnt[s], exp_ovr[s], exp_brk[s]);
        end
    endtask

    task automatic check_all_zero(input int s, input string name);
        checks++;
        if ({v[s], pe[s], fe[s], brk[s], ovr[s]} !== 5'b0 || head(s) !== 11'd0) begin
            failures++;
            $display("FAIL %s: valid=%b word=%h break=%b overrun=%b required all 0",
                     name, v[s], head(s), brk[s], ovr[s]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pin[i] = 1'b1;
            ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_all_zero(i, "reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) check_all_zero(i, "post_reset_idle");
    endtask

    task automatic test_slow_a5();
        int c = cyc_a[0];
        int wait_cnt = 0;
        fork
            send_frame(0, 9'h0A5, 1'b0, 1'b0, -1, c);
            begin
                while (v[0] !== 1'b1 && wait_cnt < 12 * c) begin
                    @(negedge clk);
                    wait_cnt++;
                end
            end
        join
        checks++;
        if (wait_cnt < 9 * c + c / 2 || wait_cnt > 9 * c + c / 2 + 6) begin
            failures++;
            $display("FAIL slow_latency: cycles=%0d required %0d..%0d", wait_cnt, 9 * c + c / 2, 9 * c + c / 2 + 6);
        end
        drain_check(0, "slow_a5");
        check_counts(0, "slow_a5");
    endtask

    task automatic test_parity();
        send_frame(2, 9'h035, 1'b0, 1'b0, -1, cyc_a[2]);
        send_frame(2, 9'h035, 1'b1, 1'b0, -1, cyc_a[2]);
        drain_check(2, "parity_directed");
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 3; k++) begin
                logic [8:0] dv;
                dv = ($urandom % 4 == 0) ? 9'd0 : 9'($urandom_range(0, 127));
                send_frame(2, dv, 1'($urandom % 2), 1'($urandom % 2), -1, cyc_a[2]);
            end
            drain_check(2, "parity_random");
        end
        check_counts(2, "parity_random");
    endtask

    task automatic test_glitch();
        pin[1] = 1'b0;
        repeat (cyc_a[1] / 2 - 5) @(negedge clk);
        pin[1] = 1'b1;
        repeat (12 * cyc_a[1]) @(negedge clk);
        drain_check(1, "start_glitch");
        send_frame(1, 9'h0FF, 1'b0, 1'b0, 3, cyc_a[1]);
        drain_check(1, "data_glitch");
    endtask

    task automatic test_frame_err();
        send_frame(1, 9'h03C, 1'b0, 1'b1, -1, cyc_a[1]);
        repeat (cyc_a[1]) @(negedge clk);
        drain_check(1, "frame_err");
        check_counts(1, "frame_err");
    endtask

    task automatic test_break();
        pin[1] = 1'b0;
        repeat (20 * cyc_a[1]) @(negedge clk);
        pin[1] = 1'b1;
        repeat (3 * cyc_a[1]) @(negedge clk);
        exp_q[1].push_back({1'b1, 1'b0, 9'd0});
        exp_brk[1]++;
        drain_check(1, "break");
        check_counts(1, "break");
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(1, 9'(i), 1'b0, 1'b0, -1, cyc_a[1]);
        repeat (4) @(negedge clk);
        check_counts(1, "overrun");
        drain_check(1, "overrun_order");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++)
            send_frame(1, 9'($urandom_range(0, 255)), 1'b0, 1'b0, -1, cyc_a[1] / 2 + 2);
        repeat (cyc_a[1]) @(negedge clk);
        drain_check(1, "b2b_8n1");
        for (int k = 0; k < 4; k++)
            send_frame(2, 9'($urandom_range(1, 127)), 1'($urandom % 2), 1'b0, -1, cyc_a[2] / 2 + 2);
        repeat (cyc_a[2]) @(negedge clk);
        drain_check(2, "b2b_7e2");
        check_counts(1, "b2b_8n1");
        check_counts(2, "b2b_7e2");
    endtask

    task automatic test_reset_mid();
        int c = cyc_a[1];
        send_frame(1, 9'h011, 1'b0, 1'b0, -1, c);
        repeat (4) @(negedge clk);
        fork
            send_frame(1, 9'h05B, 1'b0, 1'b0, -1, c);
            begin
                repeat (5 * c + c / 2) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_all_zero(1, "reset_mid");
            end
        join
        exp_q[1].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(1, 9'h05A, 1'b0, 1'b0, -1, c);
        repeat (4) @(negedge clk);
        drain_check(1, "after_reset_5a");
    endtask

    initial begin
        test_reset();
        test_slow_a5();
        test_parity();
        test_glitch();
        test_frame_err();
        test_break();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_ext.md
Name: uart_rx_fifo_ext

Overview:
Parametrised UART receiver and the successor to the fixed 8N1 receiver. Configurable data width, parity and stop bits are set at elaboration. Adds 3-sample majority voting, false-start rejection, parity, framing and break detection. Received words go into an internal FIFO, which presents them on a valid/ready output, so back-pressure no longer stalls the line. Sits between the board serial pin and any byte-stream consumer in the testbench/NoC debug path.

Parameters:
CLK_FRE, 50, clock frequency in MHz
BAUD_RATE, 115200, serial baud rate; CYCLE = CLK_FRE*1000000/BAUD_RATE, CYCLE >= 8 required
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, output FIFO entries, power of 2, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx_pin  in  1  serial input, asynchronous to clk
rx_data  out  DATA_BITS  FIFO head data, LSB = first received bit
rx_parity_err  out  1  parity error flag of head word (0 when PARITY=0)
rx_frame_err  out  1  framing error flag of head word
rx_data_valid  out  1  FIFO not empty
rx_data_ready  in  1  consumer accepts head word
rx_break  out  1  1-cycle pulse: break frame received
rx_overrun  out  1  1-cycle pulse: completed frame dropped, FIFO full

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, synchroniser flops cleared to 1 (line idle, so no false edge after reset).
- Input path: 2-flop synchroniser (s0, s1). Falling edge = s1 & ~s0. All bit sampling uses s0.
- Counter cycle_cnt counts 0..CYCLE-1 per bit period and clears on every state change.
- Bit value per period = majority of s0 at cycle_cnt = CYCLE/2-2, CYCLE/2-1, CYCLE/2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on falling edge.
  - START at cnt == CYCLE-1: majority 0 -> DATA; majority 1 -> IDLE (glitch rejected, nothing pushed).
  - DATA: bits stored LSB first. At cnt == CYCLE-1, bit_cnt increments. After bit DATA_BITS-1: -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: one period. parity_err = (XOR of data bits ^ parity bit) != (PARITY == 1 ? 1 : 0). -> STOP at cnt == CYCLE-1.
  - STOP: each stop bit is majority-sampled; any 0 sets frame_err.
    - Non-final stop bit: full period.
    - Final stop bit: leave at cnt == CYCLE/2 (right after its last sample). -> IDLE and push the frame in the same cycle.
- Break: all data bits 0, parity bit 0 (if present) and frame_err. rx_break pulses in the push cycle; the word is still pushed with frame_err = 1. IDLE needs a high-then-low edge, so a held-low line creates no further frames.
- FIFO: entry = {frame_err, parity_err, data}. Show-ahead; rx_data_valid = !empty.
  - Pop when rx_data_valid & rx_data_ready.
  - Push-to-valid latency: 1 cycle (valid rises the cycle after the push cycle when previously empty).
  - Full with push and no pop: new frame dropped, FIFO unchanged, rx_overrun pulses 1 cycle.
  - Full with push and pop in the same cycle: both occur, no overrun.
  - Empty with push and pop: pop ignored (valid was 0); push occurs.
- rx_data_ready while empty: no effect.
- Reset asserted mid-frame: frame discarded, FIFO flushed, outputs return to reset values.
- Back-to-back frames: the next start edge may come at cnt == CYCLE/2+1 of the final stop bit or later. It must be caught.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - parity-mode constants PAR_NONE / PAR_ODD / PAR_EVEN
  - a function calc_cycle(clk_fre, baud) and a majority3 function
- One sub-module, uart_rx_sfifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH. It has push, pop, full and empty ports and uses pointers with an extra wrap bit.
- The top level holds the synchroniser, FSM, counters, shift register and error logic.

Test Plan:
- 8N1, CYCLE=434, send 0xA5 -> rx_data=0xA5, parity_err=0, frame_err=0, valid ~10*434 cycles after start edge; ready=1 pops it, valid drops next cycle.
- 7E2 (DATA_BITS=7, PARITY=2, STOP_BITS=2): send 0x35 with correct parity bit 0 -> no errors. Send 0x35 with parity bit 1 -> rx_data=0x35, parity_err=1.
- 200-cycle low glitch on idle line -> START rejects it, no push, valid stays 0. A 1-cycle low glitch at mid-bit of data bit 3 of 0xFF -> majority gives 0xFF.
- 8N1, stop bit driven 0 for 0x3C -> rx_data=0x3C, frame_err=1. Line held low for 2 frames -> one word 0x00 with frame_err=1, rx_break pulse, no second word until line returns high.
- FIFO_DEPTH=4, ready=0, send 0x01..0x05 back-to-back -> 4 entries, one rx_overrun pulse at the 5th push. Then ready=1 -> pops 0x01,0x02,0x03,0x04 in order, then valid=0.
- rst_n pulsed low during data bit 4 -> all outputs 0 immediately. Next clean frame 0x5A is received correctly.
